// File: rtl/leb128_pkg.sv
`default_nettype none
// ============================================================================
// Module      : leb128_pkg
// Description : Shared types and constants for the LEB128 immediate fetch.
//               Optional strict canonical check: LEB128_STRICT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package leb128_pkg;

    typedef logic [1:0] fsm_t;
    localparam fsm_t IDLE   = 2'd0;
    localparam fsm_t READ   = 2'd1;
    localparam fsm_t DECODE = 2'd2;
    localparam fsm_t RESP   = 2'd3;

    typedef logic [1:0] err_t;
    localparam err_t ERR_OK       = 2'd0;
    localparam err_t ERR_MEM      = 2'd1;
    localparam err_t ERR_UNTERM   = 2'd2;
    localparam err_t ERR_NONCANON = 2'd3;

    localparam int LEB_MAX32 = 5;
    localparam int LEB_MAX64 = 10;

endpackage
`default_nettype wire

// File: rtl/leb128_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : leb128_fetch_if
// Description : Request/response handshake and ROM window bus of the
//               LEB128 immediate fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface leb128_fetch_if #(
    parameter int MEM_ADDR  = 4,
    parameter int MEM_EXTRA = 4
);
    logic                          req_valid;
    logic                          req_ready;
    logic [MEM_ADDR:0]             req_addr;
    logic                          req_signed;
    logic                          req_w64;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [63:0]                   rsp_value;
    logic [3:0]                    rsp_len;
    logic [1:0]                    rsp_err;
    logic [MEM_ADDR:0]             mem_addr;
    logic [MEM_EXTRA-1:0]          mem_extra;
    logic [(2**MEM_EXTRA)*8-1:0]   mem_data;
    logic                          mem_error;

    // Core and ROM side together
    modport master (
        output req_valid, req_addr, req_signed, req_w64, rsp_ready,
               mem_data, mem_error,
        input  req_ready, rsp_valid, rsp_value, rsp_len, rsp_err,
               mem_addr, mem_extra
    );

    // Fetch stage side
    modport slave (
        input  req_valid, req_addr, req_signed, req_w64, rsp_ready,
               mem_data, mem_error,
        output req_ready, rsp_valid, rsp_value, rsp_len, rsp_err,
               mem_addr, mem_extra
    );
endinterface
`default_nettype wire

// File: rtl/leb128_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : leb128_decode_comb
// Description : Combinational signed/unsigned LEB128 decoder over a 10-byte
//               window. Strict canonical check under LEB128_STRICT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module leb128_decode_comb
    import leb128_pkg::*;
(
    input  wire logic [LEB_MAX64*8-1:0] i_win,
    input  wire logic                   i_signed,
    input  wire logic                   i_w64,
    output logic      [63:0]            o_value,
    output logic      [3:0]             o_len,
    output err_t                        o_err
);

    logic [63:0] w_raw;
    logic [6:0]  w_last;
    logic [3:0]  w_len;
    logic [3:0]  w_max;
    logic        w_found;
    logic        w_noncanon;

    always_comb begin
        w_max   = i_w64 ? 4'(LEB_MAX64) : 4'(LEB_MAX32);
        w_raw   = '0;
        w_last  = '0;
        w_len   = '0;
        w_found = 1'b0;
        for (int i = 0; i < LEB_MAX64; i++) begin
            if (i < int'(w_max) && !w_found) begin
                w_raw  = w_raw | ({57'd0, i_win[8*i +: 7]} << (7*i));
                w_last = i_win[8*i +: 7];
                if (!i_win[8*i+7]) begin
                    w_found = 1'b1;
                    w_len   = 4'(i + 1);
                end
            end
        end
        // Shifts of 64 or more leave nothing to fill
        if (i_signed && w_last[6])
            w_raw = w_raw | ({64{1'b1}} << (7*w_len));
    end

`ifdef LEB128_STRICT_EN
    always_comb begin
        w_noncanon = 1'b0;
        if (w_found && (w_len == w_max)) begin
            case ({i_signed, i_w64})
                2'b00:   w_noncanon = |i_win[38:36];
                2'b10:   w_noncanon = !((&i_win[38:35]) || !(|i_win[38:35]));
                2'b01:   w_noncanon = |i_win[78:73];
                default: w_noncanon = !((&i_win[78:72]) || !(|i_win[78:72]));
            endcase
        end
    end
`else
    assign w_noncanon = 1'b0;
`endif

    always_comb begin
        o_value = '0;
        o_len   = w_len;
        o_err   = ERR_OK;
        if (!w_found) begin
            o_len = w_max;
            o_err = ERR_UNTERM;
        end else if (w_noncanon) begin
            o_err = ERR_NONCANON;
        end else if (i_w64) begin
            o_value = w_raw;
        end else if (i_signed) begin
            o_value = {{32{w_raw[31]}}, w_raw[31:0]};
        end else begin
            o_value = {32'd0, w_raw[31:0]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/leb128_fetch.sv
`default_nettype none
// ============================================================================
// Module      : leb128_fetch
// Description : Immediate-operand fetch stage: reads a ROM window and returns
//               a decoded LEB128 value with its length. Macro: LEB128_STRICT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module leb128_fetch
    import leb128_pkg::*;
#(
    parameter int MEM_ADDR  = 4,
    parameter int MEM_EXTRA = 4
) (
    input  wire logic     clk,
    input  wire logic     reset,
    leb128_fetch_if.slave bus
);

    localparam int c_WIN_BITS = (2**MEM_EXTRA) * 8;

    fsm_t                 r_state;
    logic                 r_signed;
    logic                 r_w64;
    logic                 r_rsp_valid;
    logic [63:0]          r_value;
    logic [3:0]           r_len;
    err_t                 r_err;
    logic [MEM_ADDR:0]    r_mem_addr;
    logic [MEM_EXTRA-1:0] r_mem_extra;

    logic [63:0]          w_dec_value;
    logic [3:0]           w_dec_len;
    err_t                 w_dec_err;

    leb128_decode_comb u_decode (
        .i_win    (bus.mem_data[LEB_MAX64*8-1:0]),
        .i_signed (r_signed),
        .i_w64    (r_w64),
        .o_value  (w_dec_value),
        .o_len    (w_dec_len),
        .o_err    (w_dec_err)
    );

    generate
        if (c_WIN_BITS > LEB_MAX64*8) begin : g_unused_window
            logic w_unused_bits;
            assign w_unused_bits = ^bus.mem_data[c_WIN_BITS-1:LEB_MAX64*8];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_signed    <= 1'b0;
            r_w64       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_value     <= '0;
            r_len       <= '0;
            r_err       <= ERR_OK;
            r_mem_addr  <= '0;
            r_mem_extra <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_mem_addr  <= bus.req_addr;
                        r_mem_extra <= bus.req_w64 ? MEM_EXTRA'(LEB_MAX64 - 1)
                                                   : MEM_EXTRA'(LEB_MAX32 - 1);
                        r_signed    <= bus.req_signed;
                        r_w64       <= bus.req_w64;
                        r_state     <= READ;
                    end
                end
                READ: r_state <= DECODE;
                DECODE: begin
                    // A ROM bounds error overrides whatever the window decodes to
                    if (bus.mem_error) begin
                        r_value <= '0;
                        r_len   <= '0;
                        r_err   <= ERR_MEM;
                    end else begin
                        r_value <= w_dec_value;
                        r_len   <= w_dec_len;
                        r_err   <= w_dec_err;
                    end
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = (r_state == IDLE) && reset;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_value = r_value;
    assign bus.rsp_len   = r_len;
    assign bus.rsp_err   = r_err;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_extra = r_mem_extra;

endmodule
`default_nettype wire

// File: tb/tb_leb128_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_leb128_fetch
// Description : Directed self-checking bench for leb128_fetch with a
//               registered-output ROM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_leb128_fetch;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   upper_bound;
    int   lat;
    logic [7:0]  rom [0:31];
    logic [63:0] held_value;

    leb128_fetch_if #(.MEM_ADDR(4), .MEM_EXTRA(4)) bus ();

    leb128_fetch #(.MEM_ADDR(4), .MEM_EXTRA(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        for (int i = 0; i < 16; i++)
            bus.mem_data[8*i +: 8] <= rom[(int'(bus.mem_addr) + i) % 32];
        bus.mem_error <= (int'(bus.mem_addr) + int'(bus.mem_extra)) > upper_bound;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [4:0] a, input logic s, input logic w, output int n);
        bus.req_addr   = a;
        bus.req_signed = s;
        bus.req_w64    = w;
        bus.req_valid  = 1'b1;
        step();
        bus.req_valid  = 1'b0;
        chk("mem_addr", 64'(bus.mem_addr), 64'(a));
        chk("mem_extra", 64'(bus.mem_extra), w ? 64'd9 : 64'd4);
        n = 1;
        while (!bus.rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("rsp_valid_seen", 64'(bus.rsp_valid), 64'd1);
    endtask

    task automatic finish_rsp();
        step();
        chk("rsp_valid_drop", 64'(bus.rsp_valid), 64'd0);
        chk("req_ready_back", 64'(bus.req_ready), 64'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        upper_bound = 31;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[2] = 8'hE5; rom[3] = 8'h8E; rom[4] = 8'h26;
        rom[8] = 8'h7F; rom[9] = 8'h00;
        rom[10] = 8'h80; rom[11] = 8'h80; rom[12] = 8'h80; rom[13] = 8'h80; rom[14] = 8'h78;
        for (int i = 16; i < 26; i++) rom[i] = 8'h80;
        rom[26] = 8'hFF; rom[27] = 8'hFF; rom[28] = 8'hFF; rom[29] = 8'hFF; rom[30] = 8'h1F;
        reset = 1'b0;
        bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_signed = 1'b0; bus.req_w64 = 1'b0;
        bus.rsp_ready = 1'b1;
        step(); step();
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_value", bus.rsp_value, 64'd0);
        chk("rst_rsp_len", 64'(bus.rsp_len), 64'd0);
        chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        chk("rst_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("rst_mem_extra", 64'(bus.mem_extra), 64'd0);
        reset = 1'b1;
        step();
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);

        // ULEB 64-bit E5 8E 26
        run_req(5'd2, 1'b0, 1'b1, lat);
        chk("t1_latency", 64'(lat), 64'd3);
        chk("t1_value", bus.rsp_value, 64'd624485);
        chk("t1_len", 64'(bus.rsp_len), 64'd3);
        chk("t1_err", 64'(bus.rsp_err), 64'd0);
        finish_rsp();

        // SLEB 64-bit 7F and 00
        run_req(5'd8, 1'b1, 1'b1, lat);
        chk("t2a_value", bus.rsp_value, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2a_len", 64'(bus.rsp_len), 64'd1);
        finish_rsp();
        run_req(5'd9, 1'b1, 1'b1, lat);
        chk("t2b_value", bus.rsp_value, 64'd0);
        chk("t2b_len", 64'(bus.rsp_len), 64'd1);
        finish_rsp();

        // SLEB 32-bit 80 80 80 80 78
        run_req(5'd10, 1'b1, 1'b0, lat);
        chk("t3_value", bus.rsp_value, 64'hFFFF_FFFF_8000_0000);
        chk("t3_len", 64'(bus.rsp_len), 64'd5);
        chk("t3_err", 64'(bus.rsp_err), 64'd0);
        finish_rsp();

        // Ten continuation bytes, then the same with a ROM bounds error
        run_req(5'd16, 1'b0, 1'b1, lat);
        chk("t4_err", 64'(bus.rsp_err), 64'd2);
        chk("t4_len", 64'(bus.rsp_len), 64'd10);
        chk("t4_value", bus.rsp_value, 64'd0);
        finish_rsp();
        upper_bound = 20;
        run_req(5'd16, 1'b0, 1'b1, lat);
        chk("t4m_err", 64'(bus.rsp_err), 64'd1);
        chk("t4m_len", 64'(bus.rsp_len), 64'd0);
        chk("t4m_value", bus.rsp_value, 64'd0);
        finish_rsp();
        upper_bound = 31;

        // Backpressure
        bus.rsp_ready = 1'b0;
        run_req(5'd2, 1'b0, 1'b1, lat);
        held_value = bus.rsp_value;
        chk("bp_value_first", held_value, 64'd624485);
        for (int k = 0; k < 5; k++) begin
            bus.req_valid = 1'b1;
            bus.req_addr  = 5'd8;
            step();
            chk("bp_value", bus.rsp_value, 64'd624485);
            chk("bp_len", 64'(bus.rsp_len), 64'd3);
            chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
            chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        finish_rsp();
        step(); step();
        chk("bp_no_queue", 64'(bus.rsp_valid), 64'd0);
        chk("bp_mem_addr", 64'(bus.mem_addr), 64'd2);

        // Reset asserted during READ
        bus.req_addr = 5'd10; bus.req_signed = 1'b1; bus.req_w64 = 1'b0;
        bus.req_valid = 1'b1;
        step();
        bus.req_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("mr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mr_rsp_value", bus.rsp_value, 64'd0);
        chk("mr_rsp_len", 64'(bus.rsp_len), 64'd0);
        chk("mr_mem_addr", 64'(bus.mem_addr), 64'd0);
        chk("mr_mem_extra", 64'(bus.mem_extra), 64'd0);
        chk("mr_req_ready", 64'(bus.req_ready), 64'd0);
        step(); step();
        reset = 1'b1;
        step(); step();
        chk("mr_dropped", 64'(bus.rsp_valid), 64'd0);
        run_req(5'd10, 1'b1, 1'b0, lat);
        chk("mr_value", bus.rsp_value, 64'hFFFF_FFFF_8000_0000);
        chk("mr_len", 64'(bus.rsp_len), 64'd5);
        finish_rsp();

        // ULEB 32-bit FF FF FF FF 1F: excess bits in the final byte
        run_req(5'd26, 1'b0, 1'b0, lat);
        chk("t7_len", 64'(bus.rsp_len), 64'd5);
`ifdef LEB128_STRICT_EN
        chk("t7_err", 64'(bus.rsp_err), 64'd3);
        chk("t7_value", bus.rsp_value, 64'd0);
`else
        chk("t7_err", 64'(bus.rsp_err), 64'd0);
        chk("t7_value", bus.rsp_value, 64'h0000_0000_FFFF_FFFF);
`endif
        finish_rsp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/leb128_fetch.md
Name: leb128_fetch

Overview:
- Immediate-operand fetch stage between the code ROM (genrom) and the core's execute logic.
- On request, it reads one byte window starting at a code address and decodes a signed or unsigned LEB128 immediate (i32/i64.const, local index, branch depth).
- It returns the value and the encoded length, so the core can advance its PC and push the operand onto its result stack.

Parameters:
- MEM_ADDR, 4, ROM address MSB index; address ports are MEM_ADDR+1 bits wide.
- MEM_EXTRA, 4, ROM window size exponent; window = 2**MEM_EXTRA bytes, must be ≥ 10.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  decode request.
- req_ready  out  1  block is idle and accepts a request.
- req_addr  in  MEM_ADDR+1  address of the first LEB byte.
- req_signed  in  1  1 = SLEB128, 0 = ULEB128.
- req_w64  in  1  1 = 64-bit target (max 10 bytes), 0 = 32-bit target (max 5 bytes).
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts the result.
- rsp_value  out  64  decoded value; a 32-bit signed result is sign-extended to 64 bits.
- rsp_len  out  4  encoded byte count, 1..10.
- rsp_err  out  2  0 = ok, 1 = ROM error, 2 = unterminated/too long, 3 = non-canonical (strict mode only).
- mem_addr  out  MEM_ADDR+1  ROM address.
- mem_extra  out  MEM_EXTRA  ROM extra-byte count.
- mem_data  in  2**MEM_EXTRA*8  ROM window; byte at mem_addr+i is mem_data[8*i +: 8].
- mem_error  in  1  ROM bounds error for the current window.

Behaviour:
- Reset state (asserted any time, including mid-operation): FSM goes to IDLE; req_ready=1 once reset is released; rsp_valid=0, rsp_value=0, rsp_len=0, rsp_err=0, mem_addr=0, mem_extra=0. Any in-flight request is dropped.
- FSM states: IDLE, READ, DECODE, RESP.
  - IDLE: req_ready=1. When req_valid=1, register addr, signed and w64; drive mem_addr=req_addr and mem_extra=(w64 ? 9 : 4); go to READ.
  - READ: one-cycle wait for the registered ROM output. Go to DECODE.
  - DECODE: combinational scan of bytes 0..MAX-1, where MAX = w64 ? 10 : 5.
    - len = index of the first byte with bit7=0, plus 1.
    - value = OR of the 7-bit groups, each shifted by 7*i.
    - If signed and the last group's bit6=1, fill all bits above 7*len with 1s.
    - If 32-bit, truncate to 32 bits, then sign- or zero-extend to 64.
    - Register the results; go to RESP.
  - RESP: rsp_valid=1. When rsp_ready=1, go to IDLE; rsp_valid drops the next cycle.
- Latency: request accepted at cycle N gives rsp_valid at N+3. Peak throughput is one decode per 4 cycles.
- Error precedence: mem_error sampled in DECODE → err=1, value=0, len=0. Otherwise, no terminator within MAX bytes → err=2, value=0, len=MAX.
- Backpressure: while rsp_ready=0, rsp_value, rsp_len and rsp_err hold stable and req_ready=0.
- req_valid while not IDLE is ignored; requests are never queued.
- Address wrap: mem_addr carries no extra-byte arithmetic; the ROM owns window wrap and bounds checking.

Optional Feature:
- Macro: LEB128_STRICT_EN.
- When defined, DECODE also checks canonical encoding of the final byte at the maximum length:
  - unsigned 32-bit: byte 4 bits 6:4 must be 0;
  - signed 32-bit: byte 4 bits 6:3 must all equal bit 3;
  - unsigned 64-bit: byte 9 bits 6:1 must be 0;
  - signed 64-bit: byte 9 bits 6:0 must all equal bit 0.
  - Violation → err=3, value=0.
- When undefined, the excess bits are silently discarded and err=3 is never produced.

Decomposition:
- Shared package leb128_pkg holds:
  - typedef fsm_t {IDLE, READ, DECODE, RESP};
  - typedef err_t {ERR_OK, ERR_MEM, ERR_UNTERM, ERR_NONCANON};
  - constants LEB_MAX32=5 and LEB_MAX64=10.
- One combinational sub-module, leb128_decode_comb: takes window bytes, signed and w64; produces value, len and err. It is reusable by a future multi-immediate fetch (memarg).

Test Plan:
- ULEB, bytes E5 8E 26 at addr 2, w64=1 → rsp_value=624485, len=3, err=0, rsp_valid exactly 3 cycles after acceptance.
- SLEB, byte 7F, w64=1 → rsp_value=64'hFFFF_FFFF_FFFF_FFFF, len=1. Byte 00 → value 0, len=1.
- SLEB 32-bit, bytes 80 80 80 80 78 → value=64'hFFFF_FFFF_8000_0000, len=5, err=0.
- ULEB 64-bit, ten bytes of 80 → err=2, len=10, value=0. Same request with rom_upper_bound below the window → err=1.
- Backpressure: hold rsp_ready=0 for 5 cycles → outputs stable, req_ready=0, second req_valid ignored. Then assert rsp_ready → IDLE next cycle.
- Drop reset to 0 during READ → all outputs 0 immediately. After release, a new request decodes correctly. With LEB128_STRICT_EN defined, ULEB32 FF FF FF FF 1F → err=3; without the macro → value=32'hFFFF_FFFF, err=0.
